hazard_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 5-stage RV32I core.
- Produces the forwarding-mux selects consumed by the EX stage.
- Produces per-register load enables, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks freeze/halt state and keeps hazard performance counters.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: EX forwarding
// selects, pipeline-register enables, bubble/flush, freeze/halt FSM and perf counters.
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic [4:0]       EX_rs1_i,
   input  logic [4:0]       EX_rs2_i,
   input  logic [4:0]       EX_rd_i,
   input  logic             EX_mem_read_i,
   input  logic             EX_is_br_i,
   input  logic             EX_br_en_i,
   input  logic             EX_br_pred_i,
   input  logic [4:0]       MEM_rd_i,
   input  logic             MEM_load_regfile_i,
   input  logic [4:0]       WB_rd_i,
   input  logic             WB_load_regfile_i,
   input  logic             WB_halt_en_i,
   input  logic             imem_busy_i,
   input  logic             dmem_busy_i,
   output logic [1:0]       EX_forwardA_o,
   output logic [1:0]       EX_forwardB_o,
   output logic             load_pc_o,
   output logic             load_if_id_o,
   output logic             load_id_ex_o,
   output logic             load_ex_mem_o,
   output logic             load_mem_wb_o,
   output logic             bubble_id_ex_o,
   output logic             flush_if_id_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [1:0]       state_dbg_o
);

   localparam logic [1:0] FWD_ID_EX  = 2'b00;
   localparam logic [1:0] FWD_EX_MEM = 2'b01;
   localparam logic [1:0] FWD_MEM_WB = 2'b10;

   // Debug encoding on state_dbg_o: RUN=0, FREEZE=1, HALT=2.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FREEZE = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

   state_t           state_q, state_d, state_eff;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [4:0]       loads;
   logic             stall_inc, flush_inc;
   logic             busy, mispred, load_use;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (MEM_load_regfile_i && (MEM_rd_i != 5'd0) && (MEM_rd_i == rs))
         return FWD_EX_MEM;
      else if (WB_load_regfile_i && (WB_rd_i != 5'd0) && (WB_rd_i == rs))
         return FWD_MEM_WB;
      else
         return FWD_ID_EX;
   endfunction

   assign EX_forwardA_o = fwd_sel(EX_rs1_i);
   assign EX_forwardB_o = fwd_sel(EX_rs2_i);

   assign busy     = imem_busy_i | dmem_busy_i;
   assign mispred  = EX_is_br_i && (EX_br_en_i != EX_br_pred_i);
   assign load_use = EX_mem_read_i && (EX_rd_i != 5'd0) &&
                     ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

   // While reset is asserted the outputs behave as RUN regardless of the stored state.
   assign state_eff = rst ? state_q : ST_RUN;

   always_comb begin
      loads          = 5'b00000;
      bubble_id_ex_o = 1'b0;
      flush_if_id_o  = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      state_d        = state_eff;
      case (state_eff)
         ST_RUN, ST_FREEZE: begin
            if (busy) begin
               stall_inc = 1'b1;
               state_d   = ST_FREEZE;
            end else begin
               // A mispredict flushes the ID instruction, so it outranks load-use.
               if (mispred) begin
                  loads          = 5'b11111;
                  flush_if_id_o  = 1'b1;
                  bubble_id_ex_o = 1'b1;
                  flush_inc      = 1'b1;
               end else if (load_use) begin
                  loads          = 5'b00111;
                  bubble_id_ex_o = 1'b1;
                  stall_inc      = 1'b1;
               end else begin
                  loads = 5'b11111;
               end
               state_d = WB_halt_en_i ? ST_HALT : ST_RUN;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   assign {load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o} = loads;

   assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   assign flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halted_o    = (state_eff == ST_HALT);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, every cycle
// compared against a rule-level reference model of the hazard controller.
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       ID_rs1_i, ID_rs2_i, EX_rs1_i, EX_rs2_i, EX_rd_i;
   logic             EX_mem_read_i, EX_is_br_i, EX_br_en_i, EX_br_pred_i;
   logic [4:0]       MEM_rd_i, WB_rd_i;
   logic             MEM_load_regfile_i, WB_load_regfile_i, WB_halt_en_i;
   logic             imem_busy_i, dmem_busy_i;
   logic [1:0]       EX_forwardA_o, EX_forwardB_o;
   logic             load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o;
   logic             bubble_id_ex_o, flush_if_id_o, halted_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic [1:0]       state_dbg_o;

   int n_cmp = 0;
   int n_err = 0;

   // model state: 0 run, 1 freeze, 2 halt
   int m_state, m_stall, m_flush;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
      .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_rd_i(EX_rd_i),
      .EX_mem_read_i(EX_mem_read_i), .EX_is_br_i(EX_is_br_i),
      .EX_br_en_i(EX_br_en_i), .EX_br_pred_i(EX_br_pred_i),
      .MEM_rd_i(MEM_rd_i), .MEM_load_regfile_i(MEM_load_regfile_i),
      .WB_rd_i(WB_rd_i), .WB_load_regfile_i(WB_load_regfile_i),
      .WB_halt_en_i(WB_halt_en_i),
      .imem_busy_i(imem_busy_i), .dmem_busy_i(dmem_busy_i),
      .EX_forwardA_o(EX_forwardA_o), .EX_forwardB_o(EX_forwardB_o),
      .load_pc_o(load_pc_o), .load_if_id_o(load_if_id_o), .load_id_ex_o(load_id_ex_o),
      .load_ex_mem_o(load_ex_mem_o), .load_mem_wb_o(load_mem_wb_o),
      .bubble_id_ex_o(bubble_id_ex_o), .flush_if_id_o(flush_if_id_o),
      .halted_o(halted_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .state_dbg_o(state_dbg_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] loads_vec();
      return {load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o};
   endfunction

   function automatic int fwd_ref(input logic [4:0] rs);
      if (MEM_load_regfile_i && MEM_rd_i != 0 && MEM_rd_i == rs) return 1;
      if (WB_load_regfile_i && WB_rd_i != 0 && WB_rd_i == rs) return 2;
      return 0;
   endfunction

   task automatic set_idle();
      {ID_rs1_i, ID_rs2_i, EX_rs1_i, EX_rs2_i, EX_rd_i, MEM_rd_i, WB_rd_i} = '0;
      {EX_mem_read_i, EX_is_br_i, EX_br_en_i, EX_br_pred_i} = '0;
      {MEM_load_regfile_i, WB_load_regfile_i, WB_halt_en_i, imem_busy_i, dmem_busy_i} = '0;
   endtask

   // Inputs are set at the falling edge; check, then advance the model across the rising edge.
   task automatic cycle();
      int  eff, exp_loads, exp_bub, exp_fl, st_inc, fl_inc;
      bit  busy, mis, lu;
      #1;
      eff  = rst ? m_state : 0;
      busy = imem_busy_i || dmem_busy_i;
      mis  = EX_is_br_i && (EX_br_en_i != EX_br_pred_i);
      lu   = EX_mem_read_i && EX_rd_i != 0 && (EX_rd_i == ID_rs1_i || EX_rd_i == ID_rs2_i);
      exp_loads = 0; exp_bub = 0; exp_fl = 0; st_inc = 0; fl_inc = 0;
      if (eff == 2) begin
      end else if (busy) st_inc = 1;
      else if (mis) begin exp_loads = 'h1f; exp_bub = 1; exp_fl = 1; fl_inc = 1; end
      else if (lu) begin exp_loads = 'h07; exp_bub = 1; st_inc = 1; end
      else exp_loads = 'h1f;
      check("fwdA", EX_forwardA_o, fwd_ref(EX_rs1_i));
      check("fwdB", EX_forwardB_o, fwd_ref(EX_rs2_i));
      check("loads", loads_vec(), exp_loads);
      check("bubble", bubble_id_ex_o, exp_bub);
      check("flush", flush_if_id_o, exp_fl);
      check("halted", halted_o, (eff == 2) ? 1 : 0);
      check("stall_cnt", stall_cnt_o, m_stall);
      check("flush_cnt", flush_cnt_o, m_flush);
      check("state", state_dbg_o, m_state);
      @(posedge clk);
      if (!rst) begin
         m_state = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (st_inc != 0 && m_stall < CNT_MAX) m_stall++;
         if (fl_inc != 0 && m_flush < CNT_MAX) m_flush++;
         if (eff == 2) m_state = 2;
         else if (busy) m_state = 1;
         else if (WB_halt_en_i) m_state = 2;
         else m_state = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_state = 0; m_stall = 0; m_flush = 0;
      cycle();
      rst = 1'b1;
      cycle();
      check("reset_stall", stall_cnt_o, 0);

      // forwarding patterns
      MEM_rd_i = 3; MEM_load_regfile_i = 1; WB_rd_i = 3; WB_load_regfile_i = 1; EX_rs1_i = 3;
      #1 check("fwdA_mem_prio", EX_forwardA_o, 2'b01);
      cycle();
      set_idle(); MEM_load_regfile_i = 1; WB_load_regfile_i = 1;
      #1 check("fwdA_x0", EX_forwardA_o, 2'b00);
      cycle();
      set_idle(); WB_rd_i = 7; WB_load_regfile_i = 1; EX_rs2_i = 7;
      #1 check("fwdB_wb", EX_forwardB_o, 2'b10);
      cycle();

      // load-use
      set_idle(); EX_mem_read_i = 1; EX_rd_i = 5; ID_rs2_i = 5;
      #1 check("lu_pc", load_pc_o, 0);
      cycle();
      check("lu_stall_cnt", stall_cnt_o, 1);
      EX_mem_read_i = 0;
      #1 check("lu_release", loads_vec(), 5'b11111);
      cycle();

      // mispredict beats load-use
      EX_mem_read_i = 1; EX_is_br_i = 1; EX_br_en_i = 1; EX_br_pred_i = 0;
      #1 check("mis_flush", flush_if_id_o, 1);
      cycle();
      check("mis_flush_cnt", flush_cnt_o, 1);
      check("mis_stall_cnt", stall_cnt_o, 1);

      // dmem busy for 4 cycles with the mispredict waiting in EX
      dmem_busy_i = 1;
      repeat (4) cycle();
      check("frz_state", state_dbg_o, 1);
      check("frz_stall_cnt", stall_cnt_o, 5);
      dmem_busy_i = 0;
      #1 check("frz_release_flush", flush_if_id_o, 1);
      cycle();
      check("frz_flush_cnt", flush_cnt_o, 2);

      // halt, then reset out of it
      set_idle(); WB_halt_en_i = 1;
      cycle();
      check("halt_on", halted_o, 1);
      WB_halt_en_i = 0;
      #1 check("halt_loads", loads_vec(), 5'b00000);
      cycle(); cycle();
      rst = 1'b0;
      #1 check("rst_loads", loads_vec(), 5'b11111);
      cycle();
      rst = 1'b1;
      check("rst_halted", halted_o, 0);
      check("rst_flush_cnt", flush_cnt_o, 0);
      cycle();

      // saturation
      imem_busy_i = 1;
      repeat (CNT_MAX + 3) cycle();
      check("sat_stall", stall_cnt_o, CNT_MAX);
      imem_busy_i = 0;
      cycle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         ID_rs1_i = 5'($urandom_range(0, 7));
         ID_rs2_i = 5'($urandom_range(0, 7));
         EX_rs1_i = 5'($urandom_range(0, 7));
         EX_rs2_i = 5'($urandom_range(0, 7));
         EX_rd_i  = 5'($urandom_range(0, 7));
         MEM_rd_i = 5'($urandom_range(0, 7));
         WB_rd_i  = 5'($urandom_range(0, 7));
         EX_mem_read_i      = 1'($urandom_range(0, 1));
         EX_is_br_i         = 1'($urandom_range(0, 1));
         EX_br_en_i         = 1'($urandom_range(0, 1));
         EX_br_pred_i       = 1'($urandom_range(0, 1));
         MEM_load_regfile_i = 1'($urandom_range(0, 1));
         WB_load_regfile_i  = 1'($urandom_range(0, 1));
         WB_halt_en_i       = ($urandom_range(0, 39) == 0);
         imem_busy_i        = ($urandom_range(0, 5) == 0);
         dmem_busy_i        = ($urandom_range(0, 5) == 0);
         rst                = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
